// File: rtl/isb_pkg.sv
// Shared ISB definitions: field widths, confidence limits and the training FSM states.
// Also used by the prefetch issuer.
package isb_pkg;
   localparam int ADDR_W         = 16;
   localparam int SA_W           = 32;
   localparam int CONF_W         = 2;
   localparam int STREAM_LEN_DEF = 16;
   localparam logic [CONF_W-1:0] CONF_MAX = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_A   = 3'd1,
      ST_RD_B   = 3'd2,
      ST_DECIDE = 3'd3,
      ST_WR_A   = 3'd4,
      ST_WR_B   = 3'd5
   } isb_state_e;

   function automatic logic [CONF_W-1:0] conf_sat_inc(input logic [CONF_W-1:0] c);
      if (c == CONF_MAX) begin
         return CONF_MAX;
      end else begin
         return c + 2'd1;
      end
   endfunction
endpackage

// File: rtl/isb_sa_alloc.sv
// Next-free structural-address allocator: each alloc strobe hands out the current
// value and advances by one stream length (wrapping modulo 2^SA_W).
module isb_sa_alloc
   import isb_pkg::*;
#(
   parameter int STREAM_LEN = STREAM_LEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_alloc,
   output logic [SA_W-1:0] o_sa
);
   logic [SA_W-1:0] r_next_sa;

   // Allocator register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_next_sa <= 32'd0;
      end else if (i_alloc) begin
         r_next_sa <= r_next_sa + SA_W'(STREAM_LEN);
      end
   end

   assign o_sa = r_next_sa;
endmodule

// File: rtl/isb_train_ctrl.sv
// ISB training sequencer: reads PS-AMC for (A, B), assigns SAs / updates confidence,
// then issues the PS-AMC and SP-AMC writes. One pair in flight at a time.
module isb_train_ctrl
   import isb_pkg::*;
#(
   parameter int STREAM_LEN = STREAM_LEN_DEF,
   parameter int CONF_INIT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pair_v,
   output logic              pair_ready,
   input  logic [ADDR_W-1:0] pair_a,
   input  logic [ADDR_W-1:0] pair_b,
   output logic              ps_rd_v,
   output logic [ADDR_W-1:0] ps_rd_addr,
   input  logic              ps_rd_hit,
   input  logic [SA_W-1:0]   ps_rd_sa,
   input  logic [CONF_W-1:0] ps_rd_conf,
   output logic              ps_wr_v,
   output logic [ADDR_W-1:0] ps_wr_addr,
   output logic [SA_W-1:0]   ps_wr_sa,
   output logic [CONF_W-1:0] ps_wr_conf,
   output logic              sp_wr_v,
   output logic [SA_W-1:0]   sp_wr_sa,
   output logic [ADDR_W-1:0] sp_wr_pa,
   output logic [SA_W-1:0]   next_sa
);
   localparam logic [SA_W-1:0]   LP_MASK = SA_W'(STREAM_LEN - 1);
   localparam logic [CONF_W-1:0] LP_CINIT = CONF_W'(CONF_INIT);

   isb_state_e        r_state, w_next_state;
   logic [ADDR_W-1:0] r_a, r_b;
   logic              r_hit_a;
   logic [SA_W-1:0]   r_sa_a_old;
   logic [SA_W-1:0]   r_b_sa;
   logic [CONF_W-1:0] r_b_conf;
   logic              r_b_sp;

   logic              w_alloc, w_stream_end;
   logic [SA_W-1:0]   w_alloc_sa, w_sa_a, w_tgt;
   logic [SA_W-1:0]   w_b_sa;
   logic [CONF_W-1:0] w_b_conf;
   logic              w_b_sp;

   logic              r_pair_ready, r_ps_rd_v, r_ps_wr_v, r_sp_wr_v;
   logic [ADDR_W-1:0] r_ps_rd_addr, r_ps_wr_addr, r_sp_wr_pa;
   logic [SA_W-1:0]   r_ps_wr_sa, r_sp_wr_sa;
   logic [CONF_W-1:0] r_ps_wr_conf;

   isb_sa_alloc #(.STREAM_LEN(STREAM_LEN)) u_alloc (
      .clk     (clk),
      .rst     (rst),
      .i_alloc (w_alloc),
      .o_sa    (w_alloc_sa)
   );

   // A fresh allocation is stream-aligned, so only a hit A can sit at stream end:
   // the single allocation per pair serves either the new A or the new-stream target.
   assign w_sa_a       = r_hit_a ? r_sa_a_old : w_alloc_sa;
   assign w_stream_end = ((w_sa_a & LP_MASK) == LP_MASK);
   assign w_tgt        = w_stream_end ? w_alloc_sa : (w_sa_a + 32'd1);
   assign w_alloc      = (r_state == ST_DECIDE) && (!r_hit_a || w_stream_end);

   // B-entry decision from the B read return (valid in DECIDE)
   always_comb begin
      w_b_sa   = w_tgt;
      w_b_conf = LP_CINIT;
      w_b_sp   = 1'b1;
      if (ps_rd_hit) begin
         if (ps_rd_sa == w_tgt) begin
            w_b_sa   = ps_rd_sa;
            w_b_conf = conf_sat_inc(ps_rd_conf);
            w_b_sp   = 1'b0;
         end else if (ps_rd_conf >= 2'd2) begin
            w_b_sa   = ps_rd_sa;
            w_b_conf = ps_rd_conf - 2'd1;
            w_b_sp   = 1'b0;
         end else begin
            w_b_sa   = w_tgt;
            w_b_conf = LP_CINIT;
            w_b_sp   = 1'b1;
         end
      end else begin
         w_b_sp = 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (pair_v && (pair_a != pair_b)) begin
               w_next_state = ST_RD_A;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_RD_A:   w_next_state = ST_RD_B;
         ST_RD_B:   w_next_state = ST_DECIDE;
         ST_DECIDE: w_next_state = ST_WR_A;
         ST_WR_A:   w_next_state = ST_WR_B;
         ST_WR_B:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Latched pair and per-pair read results
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a        <= 16'd0;
         r_b        <= 16'd0;
         r_hit_a    <= 1'b0;
         r_sa_a_old <= 32'd0;
         r_b_sa     <= 32'd0;
         r_b_conf   <= 2'd0;
         r_b_sp     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (pair_v) begin
                  r_a <= pair_a;
                  r_b <= pair_b;
               end
            end
            ST_RD_B: begin
               r_hit_a    <= ps_rd_hit;
               r_sa_a_old <= ps_rd_sa;
            end
            ST_DECIDE: begin
               r_b_sa   <= w_b_sa;
               r_b_conf <= w_b_conf;
               r_b_sp   <= w_b_sp;
            end
            default: begin
               r_b_sp <= r_b_sp;
            end
         endcase
      end
   end

   // Registered handshake and memory-port outputs, set up for the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pair_ready <= 1'b1;
         r_ps_rd_v    <= 1'b0;
         r_ps_rd_addr <= 16'd0;
         r_ps_wr_v    <= 1'b0;
         r_ps_wr_addr <= 16'd0;
         r_ps_wr_sa   <= 32'd0;
         r_ps_wr_conf <= 2'd0;
         r_sp_wr_v    <= 1'b0;
         r_sp_wr_sa   <= 32'd0;
         r_sp_wr_pa   <= 16'd0;
      end else begin
         r_pair_ready <= (w_next_state == ST_IDLE);
         r_ps_rd_v    <= (w_next_state == ST_RD_A) || (w_next_state == ST_RD_B);
         r_ps_rd_addr <= (w_next_state == ST_RD_A) ? pair_a : r_b;
         r_ps_wr_v    <= 1'b0;
         r_sp_wr_v    <= 1'b0;
         if (w_next_state == ST_WR_A) begin
            r_ps_wr_v    <= !r_hit_a;
            r_ps_wr_addr <= r_a;
            r_ps_wr_sa   <= w_sa_a;
            r_ps_wr_conf <= LP_CINIT;
            r_sp_wr_v    <= !r_hit_a;
            r_sp_wr_sa   <= w_sa_a;
            r_sp_wr_pa   <= r_a;
         end else if (w_next_state == ST_WR_B) begin
            r_ps_wr_v    <= 1'b1;
            r_ps_wr_addr <= r_b;
            r_ps_wr_sa   <= r_b_sa;
            r_ps_wr_conf <= r_b_conf;
            r_sp_wr_v    <= r_b_sp;
            r_sp_wr_sa   <= r_b_sa;
            r_sp_wr_pa   <= r_b;
         end
      end
   end

   assign pair_ready = r_pair_ready;
   assign ps_rd_v    = r_ps_rd_v;
   assign ps_rd_addr = r_ps_rd_addr;
   assign ps_wr_v    = r_ps_wr_v;
   assign ps_wr_addr = r_ps_wr_addr;
   assign ps_wr_sa   = r_ps_wr_sa;
   assign ps_wr_conf = r_ps_wr_conf;
   assign sp_wr_v    = r_sp_wr_v;
   assign sp_wr_sa   = r_sp_wr_sa;
   assign sp_wr_pa   = r_sp_wr_pa;
   assign next_sa    = w_alloc_sa;
endmodule

// File: tb/tb_isb_train_ctrl.sv
// Scoreboard bench for isb_train_ctrl: a PS-AMC model answers reads, expected writes
// are queued per pair and matched as the DUT emits them.
module tb_isb_train_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pair_v = 1'b0;
   logic        pair_ready;
   logic [15:0] pair_a = 16'd0;
   logic [15:0] pair_b = 16'd0;
   logic        ps_rd_v;
   logic [15:0] ps_rd_addr;
   logic        ps_rd_hit = 1'b0;
   logic [31:0] ps_rd_sa = 32'd0;
   logic [1:0]  ps_rd_conf = 2'd0;
   logic        ps_wr_v;
   logic [15:0] ps_wr_addr;
   logic [31:0] ps_wr_sa;
   logic [1:0]  ps_wr_conf;
   logic        sp_wr_v;
   logic [31:0] sp_wr_sa;
   logic [15:0] sp_wr_pa;
   logic [31:0] next_sa;

   int n_checks = 0;
   int n_errors = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   logic [63:0] exp_ps_q[$];
   logic [63:0] exp_sp_q[$];
   logic [33:0] mem[logic [15:0]];

   isb_train_ctrl dut (
      .clk(clk), .rst(rst), .pair_v(pair_v), .pair_ready(pair_ready),
      .pair_a(pair_a), .pair_b(pair_b),
      .ps_rd_v(ps_rd_v), .ps_rd_addr(ps_rd_addr), .ps_rd_hit(ps_rd_hit),
      .ps_rd_sa(ps_rd_sa), .ps_rd_conf(ps_rd_conf),
      .ps_wr_v(ps_wr_v), .ps_wr_addr(ps_wr_addr), .ps_wr_sa(ps_wr_sa), .ps_wr_conf(ps_wr_conf),
      .sp_wr_v(sp_wr_v), .sp_wr_sa(sp_wr_sa), .sp_wr_pa(sp_wr_pa), .next_sa(next_sa)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ps_rec(input logic [15:0] a, input logic [31:0] sa, input logic [1:0] c);
      return {14'd0, a, sa, c};
   endfunction

   function automatic logic [63:0] sp_rec(input logic [31:0] sa, input logic [15:0] pa);
      return {16'd0, sa, pa};
   endfunction

   // PS-AMC model: one-cycle read latency, writes visible to the next read
   always @(posedge clk) begin
      if (ps_rd_v && mem.exists(ps_rd_addr)) begin
         ps_rd_hit  <= 1'b1;
         ps_rd_sa   <= mem[ps_rd_addr][33:2];
         ps_rd_conf <= mem[ps_rd_addr][1:0];
      end else begin
         ps_rd_hit  <= 1'b0;
         ps_rd_sa   <= 32'd0;
         ps_rd_conf <= 2'd0;
      end
      if (ps_wr_v) mem[ps_wr_addr] = {ps_wr_sa, ps_wr_conf};
   end

   // Write monitor / scoreboard
   always @(negedge clk) begin
      if (ps_rd_v) rd_cnt++;
      if (ps_wr_v) begin
         wr_cnt++;
         if (exp_ps_q.size() == 0) chk("ps_wr_unexpected", ps_rec(ps_wr_addr, ps_wr_sa, ps_wr_conf), 64'd0);
         else chk("ps_wr", ps_rec(ps_wr_addr, ps_wr_sa, ps_wr_conf), exp_ps_q.pop_front());
      end
      if (sp_wr_v) begin
         wr_cnt++;
         if (exp_sp_q.size() == 0) chk("sp_wr_unexpected", sp_rec(sp_wr_sa, sp_wr_pa), 64'd0);
         else chk("sp_wr", sp_rec(sp_wr_sa, sp_wr_pa), exp_sp_q.pop_front());
      end
   end

   task automatic push_ps(input logic [15:0] a, input logic [31:0] sa, input logic [1:0] c);
      exp_ps_q.push_back(ps_rec(a, sa, c));
   endtask

   task automatic push_sp(input logic [31:0] sa, input logic [15:0] pa);
      exp_sp_q.push_back(sp_rec(sa, pa));
   endtask

   // Handshake one pair; returns the number of edges until pair_ready is back
   task automatic send_pair(input logic [15:0] a, input logic [15:0] b, output int n);
      int w = 0;
      while (!pair_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      if (!pair_ready) chk("ready_timeout", {63'd0, pair_ready}, 64'd1);
      pair_a = a; pair_b = b; pair_v = 1'b1;
      @(posedge clk); #1;
      pair_v = 1'b0;
      n = 0;
      while (!pair_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int n;
      int rd0, wr0;
      idle(2);
      rst = 1'b0;
      idle(1);
      chk("rst_ready", {63'd0, pair_ready}, 64'd1);
      chk("rst_next_sa", {32'd0, next_sa}, 64'd0);
      chk("rst_strobes", {61'd0, ps_rd_v, ps_wr_v, sp_wr_v}, 64'd0);

      // cold pair
      push_ps(16'h0100, 32'd0, 2'd1); push_sp(32'd0, 16'h0100);
      push_ps(16'h0104, 32'd1, 2'd1); push_sp(32'd1, 16'h0104);
      send_pair(16'h0100, 16'h0104, n);
      chk("cold_latency", 64'(n), 64'd5);
      chk("cold_next_sa", {32'd0, next_sa}, 64'd16);

      // repeated pair: confidence saturates at 3
      push_ps(16'h0104, 32'd1, 2'd2);
      send_pair(16'h0100, 16'h0104, n);
      chk("match_latency", 64'(n), 64'd5);
      push_ps(16'h0104, 32'd1, 2'd3);
      send_pair(16'h0100, 16'h0104, n);
      push_ps(16'h0104, 32'd1, 2'd3);
      send_pair(16'h0100, 16'h0104, n);
      chk("match_next_sa", {32'd0, next_sa}, 64'd16);

      // another cold pair brings next_sa to 32
      push_ps(16'h0400, 32'd16, 2'd1); push_sp(32'd16, 16'h0400);
      push_ps(16'h0404, 32'd17, 2'd1); push_sp(32'd17, 16'h0404);
      send_pair(16'h0400, 16'h0404, n);
      chk("cold2_next_sa", {32'd0, next_sa}, 64'd32);

      // stream end: saA=15 hit, B misses
      mem[16'h0300] = {32'd15, 2'd1};
      push_ps(16'h0304, 32'd32, 2'd1); push_sp(32'd32, 16'h0304);
      send_pair(16'h0300, 16'h0304, n);
      chk("end_next_sa", {32'd0, next_sa}, 64'd48);

      // mismatch: saB=7, tgt=3
      mem[16'h0500] = {32'd2, 2'd1};
      mem[16'h0504] = {32'd7, 2'd3};
      push_ps(16'h0504, 32'd7, 2'd2);
      send_pair(16'h0500, 16'h0504, n);
      mem[16'h0600] = {32'd2, 2'd2};
      mem[16'h0604] = {32'd7, 2'd1};
      push_ps(16'h0604, 32'd3, 2'd1); push_sp(32'd3, 16'h0604);
      send_pair(16'h0600, 16'h0604, n);
      chk("mismatch_next_sa", {32'd0, next_sa}, 64'd48);

      // A == B is dropped in one cycle
      rd0 = rd_cnt; wr0 = wr_cnt;
      send_pair(16'h0200, 16'h0200, n);
      chk("same_latency", 64'(n), 64'd0);
      idle(6);
      chk("same_no_rd", 64'(rd_cnt), 64'(rd0));
      chk("same_no_wr", 64'(wr_cnt), 64'(wr0));

      // reset during RD_B of a cold pair
      wr0 = wr_cnt;
      pair_a = 16'h0700; pair_b = 16'h0704; pair_v = 1'b1;
      @(posedge clk); #1;
      pair_v = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_ready", {63'd0, pair_ready}, 64'd1);
      chk("rst_mid_next_sa", {32'd0, next_sa}, 64'd0);
      idle(8);
      chk("rst_mid_no_wr", 64'(wr_cnt), 64'(wr0));

      // normal processing after the reset
      push_ps(16'h0800, 32'd0, 2'd1); push_sp(32'd0, 16'h0800);
      push_ps(16'h0804, 32'd1, 2'd1); push_sp(32'd1, 16'h0804);
      send_pair(16'h0800, 16'h0804, n);
      chk("post_rst_latency", 64'(n), 64'd5);
      chk("post_rst_next_sa", {32'd0, next_sa}, 64'd16);

      idle(4);
      chk("ps_q_drained", 64'(exp_ps_q.size()), 64'd0);
      chk("sp_q_drained", 64'(exp_sp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/isb_train_ctrl.md
# isb_train_ctrl

- Sequences one ISB training update per accepted (A, B) address pair.
- Pairs come from the training unit: A is the PC's last address, B is the current address.
- For each pair the block reads the PS-AMC for A and B, then decides the structural-address (SA) assignment and confidence update.
- It then issues PS-AMC and SP-AMC writes through single read and write ports, and owns the next-free-SA allocator.

## Interface
Parameters:
- STREAM_LEN, 16: SAs per allocated stream; power of two.
- CONF_INIT, 1: confidence written on a new or remapped PS-AMC entry.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, one clock
- pair_v  in  1  training pair valid
- pair_ready  out  1  block can accept a pair
- pair_a  in  16  previous address A
- pair_b  in  16  current address B
- ps_rd_v  out  1  PS-AMC read strobe
- ps_rd_addr  out  16  PS-AMC read tag (physical address)
- ps_rd_hit  in  1  read hit; valid one cycle after ps_rd_v
- ps_rd_sa  in  32  SA of hit entry; same timing as ps_rd_hit
- ps_rd_conf  in  2  confidence of hit entry; same timing as ps_rd_hit
- ps_wr_v  out  1  PS-AMC write strobe
- ps_wr_addr  out  16  PS-AMC write tag
- ps_wr_sa  out  32  PS-AMC write SA
- ps_wr_conf  out  2  PS-AMC write confidence
- sp_wr_v  out  1  SP-AMC write strobe
- sp_wr_sa  out  32  SP-AMC write SA
- sp_wr_pa  out  16  SP-AMC write physical address
- next_sa  out  32  current allocator value (debug)

## Operation
- FSM states: IDLE, RD_A, RD_B, DECIDE, WR_A, WR_B. Every accepted pair with A != B walks all six states in order, then returns to IDLE.
- IDLE:
  - pair_ready=1.
  - On a handshake, latch A and B.
  - If A==B, drop the pair and stay in IDLE; otherwise go to RD_A.
- RD_A: ps_rd_v=1 with addr A.
- RD_B: ps_rd_v=1 with addr B; capture hitA, saA_old from the read return.
- DECIDE: capture hitB, saB_old, confB; compute the following.
  - saA = hitA ? saA_old : next_sa. When !hitA, next_sa += STREAM_LEN.
  - tgt = (saA mod STREAM_LEN == STREAM_LEN-1) ? next_sa (after any A allocation) : saA+1. The stream-end case also advances next_sa by STREAM_LEN. At most one allocation happens per pair.
  - B case hit-match (hitB and saB_old==tgt): write conf=min(confB+1, 3); sa unchanged; no SP write.
  - B case hit-mismatch with confB>=2: write conf=confB-1; sa unchanged; no SP write.
  - B case hit-mismatch with confB<=1: remap to sa=tgt, conf=CONF_INIT, with SP write.
  - B case miss: new entry sa=tgt, conf=CONF_INIT, with SP write.
- WR_A (only if !hitA): ps_wr {A, saA, CONF_INIT} and sp_wr {saA, A}.
- WR_B: issue the ps_wr and optional sp_wr per the B case above.
- Old SP-AMC mappings are never invalidated.
- next_sa wraps modulo 2^32 silently.

## Timing
- Reset values: FSM=IDLE, pair_ready=1, all strobes 0, next_sa=0, latched A/B and results cleared.
- Handshake occurs at cycle 0; reads at cycles 1-2; decide at cycle 3; writes at cycles 4-5; pair_ready=1 again at cycle 6.
- Throughput is one pair per 6 cycles. An A==B pair takes 1 cycle.
- PS-AMC writes are visible to a read issued the following cycle. Strict serialization means no read-after-write hazard between pairs.
- Strobes are registered and high for exactly one cycle. Data outputs are don't-care when their strobe is low.
- Reset mid-operation:
  - Return to IDLE next cycle and drop the in-flight pair.
  - Writes already issued are not rolled back.
  - Writes not yet issued are never emitted.
  - next_sa returns to 0.
- pair_v while pair_ready=0 is ignored; the producer must hold the pair.

## Structure
- Shared package isb_pkg holds ADDR_W=16, SA_W=32, CONF_W=2, CONF_MAX=3, default STREAM_LEN, and the FSM state enum. The later prefetch issuer shares these.
- One sub-module, isb_sa_alloc: next_sa register with reset and an alloc strobe that returns the current value and adds STREAM_LEN.

## Test plan
- Cold pair after reset, A=0x100, B=0x104 (both miss):
  - Writes ps{0x100,0,1}, sp{0,0x100}, then ps{0x104,1,1}, sp{1,0x104}.
  - next_sa=16; pair_ready returns at cycle 6.
- Repeat A=0x100, B=0x104 with confB=1 (hit-match): only ps{0x104,1,2}; no sp_wr. A third repeat gives conf 3, and the fourth stays at 3.
- Stream end, saA=15 (hit), B misses, next_sa=32: ps{B,32,1} and sp{32,B}; next_sa=48.
- Mismatch, hitB with saB=7 while tgt=3:
  - confB=3 gives ps conf 2 and no sp_wr.
  - confB=1 gives remap ps{B,3,1} and sp{3,B}.
- A==B=0x200: no ps_rd_v, ps_wr_v or sp_wr_v; pair_ready high the next cycle.
- rst asserted in the RD_B cycle of a cold pair: no writes emitted; next_sa=0; the next pair is processed from IDLE normally.
